// File: rtl/reg_write_queue.sv
// reg_write_queue: FIFO of pending register-file writes with a newest-first lookup bypass.
// Optional REG_WQ_COALESCE_EN merges a push into the tail entry when the addresses match.
module reg_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_addr,
  input  logic [31:0]              in_data,
  input  logic                     drain_en,
  output logic                     wr_en,
  output logic [3:0]               write_addr,
  output logic [31:0]              write_data,
  input  logic [3:0]               lookup_addr,
  output logic                     lookup_hit,
  output logic [31:0]              lookup_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]  head_reg;
  logic [AW-1:0]  tail_reg;
  logic [CW-1:0]  count_reg;
  logic [3:0]     addr_mem [DEPTH];
  logic [31:0]    data_mem [DEPTH];

  logic full_int;
  logic empty_int;
  logic push;
  logic pop;
  logic coalesce;
  logic alloc;

  assign empty_int = (count_reg == '0);
  assign full_int  = (count_reg == CW'(DEPTH));
  assign push      = in_valid && !full_int;
  assign pop       = drain_en && !empty_int;

`ifdef REG_WQ_COALESCE_EN
  logic [AW-1:0] newest_idx;
  assign newest_idx = tail_reg - AW'(1);
  // A lone entry leaving this cycle cannot absorb the push; it gets a fresh slot.
  assign coalesce = push && !empty_int && (addr_mem[newest_idx] == in_addr) &&
                    !(pop && (count_reg == CW'(1)));
`else
  assign coalesce = 1'b0;
`endif

  assign alloc = push && !coalesce;

  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_mem[tail_reg] <= in_addr;
      data_mem[tail_reg] <= in_data;
    end
`ifdef REG_WQ_COALESCE_EN
    else if (coalesce) begin
      data_mem[newest_idx] <= in_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (pop) begin
        head_reg <= head_reg + AW'(1);
      end
      if (alloc) begin
        tail_reg <= tail_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(alloc) - CW'(pop);
    end
  end

  // Slot gi is live when its distance from head is below the occupancy.
  logic [DEPTH-1:0] match;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [AW-1:0] age;
    assign age       = AW'(gi) - head_reg;
    assign match[gi] = ({1'b0, age} < count_reg) && (addr_mem[gi] == lookup_addr);
  end

  logic [AW-1:0] lookup_idx;
  logic          hit_int;
  logic [31:0]   hit_data;

  always_comb begin
    lookup_idx = '0;
    hit_int    = 1'b0;
    hit_data   = '0;
    // Walk oldest to newest so the newest match wins.
    for (int k = 0; k < DEPTH; k++) begin
      lookup_idx = head_reg + AW'(k);
      if (match[lookup_idx]) begin
        hit_int  = 1'b1;
        hit_data = data_mem[lookup_idx];
      end
    end
  end

  // Outputs are forced to their idle values while reset_n is low.
  assign in_ready    = !full_int || !reset_n;
  assign wr_en       = pop && reset_n;
  assign write_addr  = (reset_n && !empty_int) ? addr_mem[head_reg] : '0;
  assign write_data  = (reset_n && !empty_int) ? data_mem[head_reg] : '0;
  assign lookup_hit  = hit_int && reset_n;
  assign lookup_data = (hit_int && reset_n) ? hit_data : '0;
  assign count       = reset_n ? count_reg : '0;
  assign full        = full_int && reset_n;
  assign empty       = empty_int || !reset_n;

endmodule

// File: tb/tb_reg_write_queue.sv
// Testbench for reg_write_queue: directed scenarios plus random traffic against a queue model.
module tb_reg_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        drain_en = 1'b0;
  logic        wr_en;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [3:0]  lookup_addr = '0;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int errors = 0;
  int checks = 0;
  int steps  = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];

  reg_write_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .drain_en    (drain_en),
    .wr_en       (wr_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational/registered outputs, advance model.
  task automatic step(input logic rst_n, input logic v, input logic [3:0] a,
                      input logic [31:0] d, input logic drain, input logic [3:0] la);
    int          n;
    logic        e_hit;
    logic [31:0] e_ldata;
    logic        pu;
    logic        po;
    logic        co;
    ent_t        e;
    @(negedge clk);
    reset_n = rst_n; in_valid = v; in_addr = a; in_data = d;
    drain_en = drain; lookup_addr = la;
    #1;
    n = rst_n ? q.size() : 0;
    e_hit = 1'b0;
    e_ldata = '0;
    for (int i = 0; i < n; i++) begin
      if (q[i].addr == la) begin
        e_hit = 1'b1;
        e_ldata = q[i].data;
      end
    end
    chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
    chk("wr_en", 32'(wr_en), 32'(drain && n > 0));
    chk("write_addr", 32'(write_addr), (n > 0) ? 32'(q[0].addr) : 32'd0);
    chk("write_data", write_data, (n > 0) ? q[0].data : 32'd0);
    chk("lookup_hit", 32'(lookup_hit), 32'(e_hit));
    chk("lookup_data", lookup_data, e_ldata);
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    $display("step %0d rst_n=%0b v=%0b a=%h d=%h drain=%0b la=%h | count=%0d wr_en=%0b waddr=%h hit=%0b",
             steps, rst_n, v, a, d, drain, la, count, wr_en, write_addr, lookup_hit);
    steps++;
    if (!rst_n) begin
      q.delete();
    end else begin
      pu = v && (q.size() < DEPTH);
      po = drain && (q.size() > 0);
      co = 1'b0;
`ifdef REG_WQ_COALESCE_EN
      co = pu && (q.size() > 0) && (q[q.size()-1].addr == a) && !(po && q.size() == 1);
`endif
      if (co) q[q.size()-1].data = d;
      if (po) void'(q.pop_front());
      if (pu && !co) begin
        e.addr = a;
        e.data = d;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h3, 32'h1234, 1'b1, 4'h3);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);

    // Single push then drain; push with drain_en=1 on empty must not fall through
    step(1'b1, 1'b1, 4'hA, 32'hFFFF_FFFF, 1'b1, 4'hA);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'hA);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'hA);

    // Fill, overflow attempt, drain in order
    for (int i = 1; i <= 5; i++)
      step(1'b1, 1'b1, 4'(i), 32'(i * 32'h1111), 1'b0, 4'(i));
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h5);

    // Steady state at count=2 with pointer wrap
    step(1'b1, 1'b1, 4'h6, 32'hA0, 1'b0, 4'h6);
    step(1'b1, 1'b1, 4'h7, 32'hA1, 1'b0, 4'h6);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 4'(8 + (i % 4)), 32'hB0 + 32'(i), 1'b1, 4'(8 + (i % 4)));
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0);

    // Newest-first lookup
    step(1'b1, 1'b1, 4'h4, 32'h5555_5555, 1'b0, 4'h4);
    step(1'b1, 1'b1, 4'h4, 32'h0, 1'b0, 4'h4);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h4);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h7);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h4);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h4);

    // Reset while holding three entries and draining
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 4'(i + 1), 32'hC0 + 32'(i), 1'b0, 4'h1);
    step(1'b0, 1'b1, 4'h9, 32'hDEAD, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h1);

    // Same-address back-to-back pushes
    step(1'b1, 1'b1, 4'hF, 32'h1, 1'b0, 4'hF);
    step(1'b1, 1'b1, 4'hF, 32'h2, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'hF);

    // Random traffic with a narrow address range to exercise lookups and merging
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 60), 4'($urandom_range(0, 3)),
           $urandom(), ($urandom_range(0, 99) < 50), 4'($urandom_range(0, 4)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
